// File: rtl/ili9341_spi_monitor.sv
`timescale 1ns/1ps
// Passive ILI9341 4-wire SPI monitor: bytes, CASET/PASET window, RAMWR RGB565 pixels (optional ILI_PIXEL_COUNT_EN adds pixel_count).
// All outputs registered; byte_valid lands SYNC_STAGES+1 clk after the physical sck edge; no backpressure (bus is only observed).
module ili9341_spi_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   input  logic        spi_cs,
   input  logic        spi_dc,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   output logic        byte_is_cmd,
   output logic        frame_err,
   output logic [7:0]  last_cmd,
   output logic [15:0] col_start,
   output logic [15:0] col_end,
   output logic [15:0] page_start,
   output logic [15:0] page_end,
   output logic        win_update,
   output logic [15:0] pixel_data,
   output logic        pixel_valid
`ifdef ILI_PIXEL_COUNT_EN
   ,output logic [16:0] pixel_count
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CASET,
      ST_PASET,
      ST_RAMWR,
      ST_OTHER
   } state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   cs_prev_q, cs_prev_d;

   logic       sck_s, mosi_s, cs_s, dc_s;
   logic       sck_rise, cs_rise, byte_done;
   logic [7:0] rx_byte;

   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q, shift_d;
   logic [1:0]  par_cnt_q, par_cnt_d;
   logic [7:0]  prm0_q, prm0_d;
   logic [7:0]  prm1_q, prm1_d;
   logic [7:0]  prm2_q, prm2_d;
   state_e      state_q, state_d;

   logic [7:0]  byte_data_q, byte_data_d;
   logic        byte_valid_q, byte_valid_d;
   logic        byte_is_cmd_q, byte_is_cmd_d;
   logic        frame_err_q, frame_err_d;
   logic [7:0]  last_cmd_q, last_cmd_d;
   logic [15:0] col_start_q, col_start_d;
   logic [15:0] col_end_q, col_end_d;
   logic [15:0] page_start_q, page_start_d;
   logic [15:0] page_end_q, page_end_d;
   logic        win_update_q, win_update_d;
   logic [15:0] pixel_data_q, pixel_data_d;
   logic        pixel_valid_q, pixel_valid_d;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign dc_s   = dc_sync_q[SYNC_STAGES-1];

   assign sck_rise  = sck_s & ~sck_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign byte_done = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
   assign rx_byte   = {shift_q, mosi_s};

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
      sck_prev_d  = sck_s;
      cs_prev_d   = cs_s;
   end

   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      par_cnt_d     = par_cnt_q;
      prm0_d        = prm0_q;
      prm1_d        = prm1_q;
      prm2_d        = prm2_q;
      state_d       = state_q;
      byte_data_d   = byte_data_q;
      byte_is_cmd_d = byte_is_cmd_q;
      last_cmd_d    = last_cmd_q;
      col_start_d   = col_start_q;
      col_end_d     = col_end_q;
      page_start_d  = page_start_q;
      page_end_d    = page_end_q;
      pixel_data_d  = pixel_data_q;
      byte_valid_d  = 1'b0;
      frame_err_d   = 1'b0;
      win_update_d  = 1'b0;
      pixel_valid_d = 1'b0;

      if (cs_rise) begin
         // End of frame: partial bytes are errors; an unpaired RAMWR byte is dropped.
         bit_cnt_d = 3'd0;
         if (bit_cnt_q != 3'd0) frame_err_d = 1'b1;
         if (state_q == ST_RAMWR) par_cnt_d = 2'd0;
      end else if (sck_rise && !cs_s) begin
         shift_d   = {shift_q[5:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
         byte_valid_d  = 1'b1;
         byte_data_d   = rx_byte;
         byte_is_cmd_d = ~dc_s;
         if (!dc_s) begin
            last_cmd_d = rx_byte;
            par_cnt_d  = 2'd0;
            case (rx_byte)
               8'h2A:   state_d = ST_CASET;
               8'h2B:   state_d = ST_PASET;
               8'h2C:   state_d = ST_RAMWR;
               default: state_d = ST_OTHER;
            endcase
         end else begin
            case (state_q)
               ST_CASET, ST_PASET: begin
                  par_cnt_d = par_cnt_q + 2'd1;
                  case (par_cnt_q)
                     2'd0: prm0_d = rx_byte;
                     2'd1: prm1_d = rx_byte;
                     2'd2: prm2_d = rx_byte;
                     default: begin
                        // Window outputs only move once all four bytes are in.
                        if (state_q == ST_CASET) begin
                           col_start_d = {prm0_q, prm1_q};
                           col_end_d   = {prm2_q, rx_byte};
                        end else begin
                           page_start_d = {prm0_q, prm1_q};
                           page_end_d   = {prm2_q, rx_byte};
                        end
                        win_update_d = 1'b1;
                        state_d      = ST_OTHER;
                     end
                  endcase
               end
               ST_RAMWR: begin
                  if (!par_cnt_q[0]) begin
                     prm0_d    = rx_byte;
                     par_cnt_d = 2'd1;
                  end else begin
                     pixel_data_d  = {prm0_q, rx_byte};
                     pixel_valid_d = 1'b1;
                     par_cnt_d     = 2'd0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_sync_q    <= '0;
         mosi_sync_q   <= '0;
         cs_sync_q     <= '1;
         dc_sync_q     <= '0;
         sck_prev_q    <= 1'b0;
         cs_prev_q     <= 1'b1;
         bit_cnt_q     <= 3'd0;
         shift_q       <= 7'd0;
         par_cnt_q     <= 2'd0;
         prm0_q        <= 8'd0;
         prm1_q        <= 8'd0;
         prm2_q        <= 8'd0;
         state_q       <= ST_IDLE;
         byte_data_q   <= 8'd0;
         byte_valid_q  <= 1'b0;
         byte_is_cmd_q <= 1'b0;
         frame_err_q   <= 1'b0;
         last_cmd_q    <= 8'd0;
         col_start_q   <= 16'h0000;
         col_end_q     <= 16'h00EF;
         page_start_q  <= 16'h0000;
         page_end_q    <= 16'h013F;
         win_update_q  <= 1'b0;
         pixel_data_q  <= 16'd0;
         pixel_valid_q <= 1'b0;
      end else begin
         sck_sync_q    <= sck_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         cs_sync_q     <= cs_sync_d;
         dc_sync_q     <= dc_sync_d;
         sck_prev_q    <= sck_prev_d;
         cs_prev_q     <= cs_prev_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         par_cnt_q     <= par_cnt_d;
         prm0_q        <= prm0_d;
         prm1_q        <= prm1_d;
         prm2_q        <= prm2_d;
         state_q       <= state_d;
         byte_data_q   <= byte_data_d;
         byte_valid_q  <= byte_valid_d;
         byte_is_cmd_q <= byte_is_cmd_d;
         frame_err_q   <= frame_err_d;
         last_cmd_q    <= last_cmd_d;
         col_start_q   <= col_start_d;
         col_end_q     <= col_end_d;
         page_start_q  <= page_start_d;
         page_end_q    <= page_end_d;
         win_update_q  <= win_update_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

`ifdef ILI_PIXEL_COUNT_EN
   logic [16:0] pix_cnt_q, pix_cnt_d;

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      if (byte_done && !dc_s && (rx_byte == 8'h2C)) begin
         pix_cnt_d = 17'd0;
      end else if (pixel_valid_d && (pix_cnt_q != 17'h1FFFF)) begin
         pix_cnt_d = pix_cnt_q + 17'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pix_cnt_q <= 17'd0;
      else      pix_cnt_q <= pix_cnt_d;
   end

   assign pixel_count = pix_cnt_q;
`endif

   assign byte_data   = byte_data_q;
   assign byte_valid  = byte_valid_q;
   assign byte_is_cmd = byte_is_cmd_q;
   assign frame_err   = frame_err_q;
   assign last_cmd    = last_cmd_q;
   assign col_start   = col_start_q;
   assign col_end     = col_end_q;
   assign page_start  = page_start_q;
   assign page_end    = page_end_q;
   assign win_update  = win_update_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_ili9341_spi_monitor.sv
`timescale 1ns/1ps
// Directed bench for ili9341_spi_monitor: byte table plus hand sequences for framing, CS frames and reset.
module tb_ili9341_spi_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, spi_sck, spi_mosi, spi_cs, spi_dc;
   logic [7:0]  byte_data, last_cmd;
   logic        byte_valid, byte_is_cmd, frame_err, win_update, pixel_valid;
   logic [15:0] col_start, col_end, page_start, page_end, pixel_data;
`ifdef ILI_PIXEL_COUNT_EN
   logic [16:0] pixel_count;
`endif

   ili9341_spi_monitor #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_dc(spi_dc),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_is_cmd(byte_is_cmd),
      .frame_err(frame_err), .last_cmd(last_cmd),
      .col_start(col_start), .col_end(col_end),
      .page_start(page_start), .page_end(page_end), .win_update(win_update),
`ifdef ILI_PIXEL_COUNT_EN
      .pixel_count(pixel_count),
`endif
      .pixel_data(pixel_data), .pixel_valid(pixel_valid)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Strobe monitors: counts are cycles high, so stretched pulses show up too.
   int bv_cnt = 0, fe_cnt = 0, wu_cnt = 0, pv_cnt = 0;
   logic [15:0] pix_log[$];
   always @(negedge clk) begin
      if (rst) begin
         if (byte_valid)  bv_cnt++;
         if (frame_err)   fe_cnt++;
         if (win_update)  wu_cnt++;
         if (pixel_valid) begin
            pv_cnt++;
            pix_log.push_back(pixel_data);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b);
      spi_mosi = b;
      step(4);
      spi_sck = 1'b1;
      step(4);
      spi_sck = 1'b0;
   endtask

   task automatic send_byte(input logic cmd, input logic [7:0] b);
      spi_dc = ~cmd;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   typedef struct {
      logic        cmd;
      logic [7:0]  b;
      logic [7:0]  lc;
      logic [15:0] cs, ce, ps, pe;
      int          wu;
      int          pv;
      logic [15:0] pd;
      logic [16:0] pc;
   } vec_t;

   vec_t vec[16];
   int base_bv, base_fe, base_wu, base_pv;
   logic [7:0] lat_b;

   initial begin
      vec[0]  = '{1'b1, 8'h2A, 8'h2A, 16'h0000, 16'h00EF, 16'h0000, 16'h013F, 0, 0, 16'h0000, 17'd0};
      vec[1]  = '{1'b0, 8'h00, 8'h2A, 16'h0000, 16'h00EF, 16'h0000, 16'h013F, 0, 0, 16'h0000, 17'd0};
      vec[2]  = '{1'b0, 8'h10, 8'h2A, 16'h0000, 16'h00EF, 16'h0000, 16'h013F, 0, 0, 16'h0000, 17'd0};
      vec[3]  = '{1'b0, 8'h00, 8'h2A, 16'h0000, 16'h00EF, 16'h0000, 16'h013F, 0, 0, 16'h0000, 17'd0};
      vec[4]  = '{1'b0, 8'h9F, 8'h2A, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 0, 16'h0000, 17'd0};
      vec[5]  = '{1'b1, 8'h2C, 8'h2C, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 0, 16'h0000, 17'd0};
      vec[6]  = '{1'b0, 8'hF8, 8'h2C, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 0, 16'h0000, 17'd0};
      vec[7]  = '{1'b0, 8'h00, 8'h2C, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 1, 16'hF800, 17'd1};
      vec[8]  = '{1'b0, 8'h07, 8'h2C, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 1, 16'hF800, 17'd1};
      vec[9]  = '{1'b0, 8'hE0, 8'h2C, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[10] = '{1'b1, 8'h2B, 8'h2B, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[11] = '{1'b0, 8'h00, 8'h2B, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[12] = '{1'b0, 8'h20, 8'h2B, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[13] = '{1'b1, 8'h36, 8'h36, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[14] = '{1'b0, 8'h00, 8'h36, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};
      vec[15] = '{1'b0, 8'h11, 8'h36, 16'h0010, 16'h009F, 16'h0000, 16'h013F, 1, 2, 16'h07E0, 17'd2};

      rst = 1'b0; spi_sck = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; spi_dc = 1'b1;
      #23;
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_byte_data", byte_data, 0);
      chk("rst_last_cmd", last_cmd, 0);
      chk("rst_col_end", col_end, 16'h00EF);
      chk("rst_page_end", page_end, 16'h013F);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_pixel_valid", pixel_valid, 0);
      step(3);
      rst = 1'b1;
      step(3);
      spi_cs = 1'b0;
      step(6);

      // Table: CASET, RAMWR pixels, aborted PASET, data in OTHER.
      base_wu = wu_cnt; base_pv = pv_cnt;
      for (int i = 0; i < 16; i++) begin
         send_byte(vec[i].cmd, vec[i].b);
         step(1);
         chk($sformatf("v%0d_byte_data", i), byte_data, vec[i].b);
         chk($sformatf("v%0d_is_cmd", i), byte_is_cmd, vec[i].cmd);
         chk($sformatf("v%0d_last_cmd", i), last_cmd, vec[i].lc);
         chk($sformatf("v%0d_col_start", i), col_start, vec[i].cs);
         chk($sformatf("v%0d_col_end", i), col_end, vec[i].ce);
         chk($sformatf("v%0d_page_start", i), page_start, vec[i].ps);
         chk($sformatf("v%0d_page_end", i), page_end, vec[i].pe);
         chk($sformatf("v%0d_win_updates", i), wu_cnt - base_wu, vec[i].wu);
         chk($sformatf("v%0d_pixels", i), pv_cnt - base_pv, vec[i].pv);
         chk($sformatf("v%0d_pixel_data", i), pixel_data, vec[i].pd);
`ifdef ILI_PIXEL_COUNT_EN
         chk($sformatf("v%0d_pixel_count", i), pixel_count, vec[i].pc);
`endif
      end

      // Partial byte then CS rise, then a full byte with a latency check on its last bit.
      base_bv = bv_cnt; base_fe = fe_cnt;
      spi_dc = 1'b1;
      send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
      step(4);
      spi_cs = 1'b1;
      step(10);
      chk("partial_frame_err", fe_cnt - base_fe, 1);
      chk("partial_no_byte", bv_cnt - base_bv, 0);
      spi_cs = 1'b0;
      step(4);
      lat_b = 8'hA5;
      for (int i = 7; i >= 1; i--) send_bit(lat_b[i]);
      spi_mosi = lat_b[0];
      step(4);
      spi_sck = 1'b1;
      @(posedge clk); #1 chk("lat_edge1", byte_valid, 0);
      @(posedge clk); #1 chk("lat_edge2", byte_valid, 0);
      @(posedge clk); #1 chk("lat_edge3", byte_valid, 1);
      chk("lat_byte_data", byte_data, 8'hA5);
      chk("lat_is_cmd", byte_is_cmd, 0);
      @(posedge clk); #1 chk("lat_one_cycle", byte_valid, 0);
      #1 spi_sck = 1'b0;
      step(4);
      chk("after_partial_bytes", bv_cnt - base_bv, 1);
      chk("after_partial_fe", fe_cnt - base_fe, 1);

      // RAMWR across two CS frames with an odd byte at the end of the first.
      base_pv = pv_cnt; base_fe = fe_cnt;
      send_byte(1, 8'h2C);
      send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
      step(2);
      chk("frame1_pixels", pv_cnt - base_pv, 1);
      spi_cs = 1'b1;
      step(8);
      spi_cs = 1'b0;
      step(4);
      send_byte(0, 8'h44); send_byte(0, 8'h55);
      step(2);
      chk("frame2_pixels", pv_cnt - base_pv, 2);
      chk("frame1_pixel", pix_log[pix_log.size()-2], 16'h1122);
      chk("frame2_pixel", pix_log[pix_log.size()-1], 16'h4455);
      chk("frames_no_fe", fe_cnt - base_fe, 0);
`ifdef ILI_PIXEL_COUNT_EN
      chk("frames_pixel_count", pixel_count, 2);
`endif

      // Asynchronous reset in the middle of a RAMWR byte.
      send_byte(0, 8'h12);
      send_bit(1); send_bit(0); send_bit(1);
      #3 rst = 1'b0;
      #1;
      chk("arst_byte_data", byte_data, 0);
      chk("arst_is_cmd", byte_is_cmd, 0);
      chk("arst_last_cmd", last_cmd, 0);
      chk("arst_col_start", col_start, 0);
      chk("arst_col_end", col_end, 16'h00EF);
      chk("arst_page_start", page_start, 0);
      chk("arst_page_end", page_end, 16'h013F);
      chk("arst_pixel_data", pixel_data, 0);
`ifdef ILI_PIXEL_COUNT_EN
      chk("arst_pixel_count", pixel_count, 0);
`endif
      step(3);
      rst = 1'b1;
      base_bv = bv_cnt; base_fe = fe_cnt; base_pv = pv_cnt;
      step(10);
      chk("post_rst_no_fe", fe_cnt - base_fe, 0);
      send_byte(0, 8'h12); send_byte(0, 8'h34);
      step(2);
      chk("post_rst_bytes", bv_cnt - base_bv, 2);
      chk("post_rst_byte_data", byte_data, 8'h34);
      chk("post_rst_no_pixel", pv_cnt - base_pv, 0);
      chk("post_rst_no_fe2", fe_cnt - base_fe, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
